// File: rtl/rca_pkg.sv
// Shared constants for the ripple-carry adder datapath.
package rca_pkg;

   localparam int unsigned RCA_N_DEFAULT = 16;

   // Unit-gate delay of one full-adder carry stage (generate + propagate-AND-carry).
   localparam int unsigned RCA_GATE_DELAY_PER_STAGE = 2;

   function automatic int unsigned rca_settle_delay(input int unsigned n);
      return n * RCA_GATE_DELAY_PER_STAGE;
   endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder; also exports the bit propagate term.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout,
   output logic p
);

   always_comb begin
      p    = a ^ b;
      s    = p ^ cin;
      cout = (a & b) | (p & cin);
   end

endmodule

// File: rtl/ripple_carry_adder.sv
// N-bit ripple-carry adder with registered S/Cout/P outputs.
// Optional signed-overflow output V is enabled by defining RCA_OVF_EN.
module ripple_carry_adder
   import rca_pkg::*;
#(
   parameter int unsigned N = RCA_N_DEFAULT
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic         Cin,
   output logic         out_valid,
   output logic [N-1:0] S,
   output logic         Cout,
   output logic [N-1:0] P
`ifdef RCA_OVF_EN
   ,
   output logic         V
`endif
);

   logic [N:0]   c;
   logic [N-1:0] s_core;
   logic [N-1:0] p_core;

   assign c[0] = Cin;

   // Carry chain: each stage's cout feeds the next stage's cin.
   for (genvar i = 0; i < N; i++) begin : g_bit
      full_adder u_fa (
         .a    (A[i]),
         .b    (B[i]),
         .cin  (c[i]),
         .s    (s_core[i]),
         .cout (c[i+1]),
         .p    (p_core[i])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         S         <= '0;
         Cout      <= 1'b0;
         P         <= '0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            S    <= s_core;
            Cout <= c[N];
            P    <= p_core;
         end
      end
   end

`ifdef RCA_OVF_EN
   // Two's-complement overflow: carry into the sign bit differs from carry out of it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         V <= 1'b0;
      end else if (in_valid) begin
         V <= c[N] ^ c[N-1];
      end
   end
`endif

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Directed-vector bench for ripple_carry_adder (16-bit), plus a short random sweep
// checked against an integer-addition model. V checks apply when RCA_OVF_EN is defined.
module tb_ripple_carry_adder;
   import rca_pkg::*;

   localparam int unsigned N = 16;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic [N-1:0] a_in, b_in;
   logic         cin;
   logic         out_valid;
   logic [N-1:0] s_out, p_out;
   logic         cout;
`ifdef RCA_OVF_EN
   logic         v_out;
`endif

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   ripple_carry_adder #(.N(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .A         (a_in),
      .B         (b_in),
      .Cin       (cin),
      .out_valid (out_valid),
      .S         (s_out),
      .Cout      (cout),
      .P         (p_out)
`ifdef RCA_OVF_EN
      ,
      .V         (v_out)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Drive on the falling edge, let one rising edge capture, sample 1 time unit later.
   task automatic drive(input logic v, input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
      @(negedge clk);
      in_valid = v;
      a_in     = a;
      b_in     = b;
      cin      = c;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic ov, input logic [N-1:0] s,
                             input logic co, input logic [N-1:0] p, input logic v);
      check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ov});
      check({tag, ".S"},         {16'd0, s_out},     {16'd0, s});
      check({tag, ".Cout"},      {31'd0, cout},      {31'd0, co});
      check({tag, ".P"},         {16'd0, p_out},     {16'd0, p});
`ifdef RCA_OVF_EN
      check({tag, ".V"},         {31'd0, v_out},     {31'd0, v});
`else
      if (v) begin end
`endif
   endtask

   initial begin
      logic [N-1:0] ra, rb;
      logic         rc;
      logic [N:0]   sum;
      logic         ovf;

      rst_n    = 1'b0;
      in_valid = 1'b1;
      a_in     = 16'hDEAD;
      b_in     = 16'hBEEF;
      cin      = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      expect_out("reset", 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);

      @(negedge clk);
      rst_n = 1'b1;

      drive(1'b1, 16'h1234, 16'h4321, 1'b0);
      expect_out("basic", 1'b1, 16'h5555, 1'b0, 16'h5115, 1'b0);

      drive(1'b1, 16'hFFFF, 16'h0001, 1'b0);
      expect_out("carry_out", 1'b1, 16'h0000, 1'b1, 16'hFFFE, 1'b0);

      drive(1'b1, 16'hFFFF, 16'h0000, 1'b1);
      expect_out("full_ripple", 1'b1, 16'h0000, 1'b1, 16'hFFFF, 1'b0);

      drive(1'b0, 16'hAAAA, 16'h5555, 1'b0);
      expect_out("hold", 1'b0, 16'h0000, 1'b1, 16'hFFFF, 1'b0);

      drive(1'b1, 16'hAAAA, 16'h5555, 1'b0);
      expect_out("alt_bits", 1'b1, 16'hFFFF, 1'b0, 16'hFFFF, 1'b0);

      drive(1'b1, 16'h7FFF, 16'h0001, 1'b0);
      expect_out("pos_ovf", 1'b1, 16'h8000, 1'b0, 16'h7FFE, 1'b1);

      drive(1'b1, 16'h8000, 16'h8000, 1'b0);
      expect_out("neg_ovf", 1'b1, 16'h0000, 1'b1, 16'h0000, 1'b1);

      drive(1'b1, 16'h0001, 16'h0001, 1'b0);
      expect_out("no_ovf", 1'b1, 16'h0002, 1'b0, 16'h0000, 1'b0);

      drive(1'b1, 16'h0000, 16'h0000, 1'b1);
      expect_out("cin_only", 1'b1, 16'h0001, 1'b0, 16'h0000, 1'b0);

      drive(1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
      expect_out("max_sum", 1'b1, 16'hFFFF, 1'b1, 16'h0000, 1'b0);

      // Asynchronous reset mid-cycle, away from any clock edge.
      #2;
      rst_n = 1'b0;
      #1;
      expect_out("async_rst", 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);

      // Pending operands while in reset must be discarded.
      @(negedge clk);
      in_valid = 1'b1;
      a_in     = 16'h00F0;
      b_in     = 16'h0F00;
      cin      = 1'b0;
      @(posedge clk);
      #1;
      expect_out("rst_hold", 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      expect_out("first_cap", 1'b1, 16'h0FF0, 1'b0, 16'h0FF0, 1'b0);

      for (int unsigned i = 0; i < 500; i++) begin
         ra  = 16'($urandom);
         rb  = 16'($urandom);
         rc  = 1'($urandom);
         sum = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
         ovf = (ra[N-1] == rb[N-1]) && (sum[N-1] != ra[N-1]);
         drive(1'b1, ra, rb, rc);
         expect_out("random", 1'b1, sum[N-1:0], sum[N], ra ^ rb, ovf);
      end

      $display("settle bound for N=%0d: %0d gate delays", N, rca_settle_delay(N));
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
